// File: rtl/score_pkg.sv
// ---------------------------------------------------------------------------
// score_pkg
// Shared definitions for the score display path: default score width and
// saturation limit, the number of BCD digits driven to the 7-segment
// decoders, and the binary-to-BCD converter FSM state type.
// ---------------------------------------------------------------------------
package score_pkg;

    // Default width of the binary score register.
    localparam int unsigned SCORE_W    = 10;

    // Default saturation limit; must stay below 10^BCD_DIGITS.
    localparam int unsigned MAX_SCORE  = 999;

    // Digits shown on the display: ones, tens, hundreds.
    localparam int unsigned BCD_DIGITS = 3;

    // Width of the BCD field of the double-dabble shift register.
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;

    // Converter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : score_pkg

// File: rtl/bcd_add3.sv
// ---------------------------------------------------------------------------
// bcd_add3
// Double-dabble correction for a single BCD nibble: a nibble of 5 or more is
// incremented by 3 so that the following left shift carries into the next
// decimal digit instead of producing a value above 9.
//
// Ports
//   nib_i  in   4  BCD nibble before correction
//   nib_o  out  4  nibble after the conditional add-3
// ---------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'd5) ? (nib_i + 4'd3) : nib_i;

endmodule : bcd_add3

// File: rtl/score_to_bcd.sv
// ---------------------------------------------------------------------------
// score_to_bcd
// Saturating score counter with a sequential binary-to-BCD converter
// (shift-and-add-3, one bit per cycle). Every change of the score, and every
// clear, marks the score dirty; the converter picks up the newest score
// whenever it is idle, so intermediate values during bursts are skipped.
// Displayed digits change only when a conversion completes, in one edge.
//
// Ports
//   clk    in   1        clock, rising edge
//   rst_n  in   1        asynchronous active-low reset
//   hit    in   1        increment score (saturates at MAX_SCORE)
//   clr    in   1        clear score; wins over a simultaneous hit
//   score  out  SCORE_W  current binary score
//   bcd0   out  4        ones digit
//   bcd1   out  4        tens digit
//   bcd2   out  4        hundreds digit
//   busy   out  1        conversion in progress (SHIFT or DONE)
//   valid  out  1        one-cycle pulse when new digits appear
// ---------------------------------------------------------------------------
module score_to_bcd #(
    parameter int unsigned SCORE_W   = score_pkg::SCORE_W,
    parameter int unsigned MAX_SCORE = score_pkg::MAX_SCORE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hit,
    input  logic               clr,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         bcd0,
    output logic [3:0]         bcd1,
    output logic [3:0]         bcd2,
    output logic               busy,
    output logic               valid
);

    import score_pkg::state_t;
    import score_pkg::IDLE;
    import score_pkg::SHIFT;
    import score_pkg::DONE;
    import score_pkg::BCD_DIGITS;
    import score_pkg::BCD_W;

    localparam int unsigned SR_W  = BCD_W + SCORE_W;
    localparam int unsigned CNT_W = $clog2(SCORE_W + 1);

    localparam logic [SCORE_W-1:0] MAX_VAL  = SCORE_W'(MAX_SCORE);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(SCORE_W - 1);

    // -----------------------------------------------------------------------
    // Score register and dirty flag
    // -----------------------------------------------------------------------
    logic [SCORE_W-1:0] score_q, score_d;
    logic               dirty_q, dirty_d;
    logic               load;

    state_t             state_q;
    logic [SR_W-1:0]    sreg_q;
    logic [SR_W-1:0]    sreg_corr;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         bcd0_q, bcd1_q, bcd2_q;
    logic               valid_q;

    // The converter takes a snapshot of the score whenever it is idle and
    // something has changed since the last snapshot.
    assign load = (state_q == IDLE) && dirty_q;

    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        score_d = score_q;
        dirty_d = dirty_q;

        if (load) begin
            dirty_d = 1'b0;
        end

        // A change in the same cycle as a load re-marks the score dirty, so
        // the value captured next is never older than the register.
        if (clr) begin
            score_d = '0;
            dirty_d = 1'b1;
        end else if (hit && (score_q < MAX_VAL)) begin
            score_d = score_q + 1'b1;
            dirty_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
            dirty_q <= 1'b0;
        end else begin
            // NOTE: state is always updated with non-blocking assignments so
            // every register samples the pre-edge values of its inputs.
            score_q <= score_d;
            dirty_q <= dirty_d;
        end
    end

    // -----------------------------------------------------------------------
    // Add-3 correction on each BCD nibble of the shift register; the binary
    // part below the BCD field passes through unchanged.
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < BCD_DIGITS; k++) begin : g_digit
        bcd_add3 u_add3 (
            .nib_i (sreg_q   [SCORE_W + 4*k +: 4]),
            .nib_o (sreg_corr[SCORE_W + 4*k +: 4])
        );
    end

    assign sreg_corr[SCORE_W-1:0] = sreg_q[SCORE_W-1:0];

    // -----------------------------------------------------------------------
    // Converter FSM with registered outputs
    //   IDLE  : wait for dirty, then load {zeros, score}
    //   SHIFT : SCORE_W cycles of correct-then-shift
    //   DONE  : publish all three digits in one edge, pulse valid
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            bcd0_q  <= 4'd0;
            bcd1_q  <= 4'd0;
            bcd2_q  <= 4'd0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (dirty_q) begin
                        sreg_q  <= {{BCD_W{1'b0}}, score_q};
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    sreg_q <= {sreg_corr[SR_W-2:0], 1'b0};
                    if (cnt_q == LAST_CNT) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    // Digits were held at their previous values until now,
                    // so the display never shows a half-converted number.
                    bcd0_q  <= sreg_q[SCORE_W     +: 4];
                    bcd1_q  <= sreg_q[SCORE_W + 4 +: 4];
                    bcd2_q  <= sreg_q[SCORE_W + 8 +: 4];
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: digit registers feed the 7-segment decoders directly.
    // -----------------------------------------------------------------------
    assign score = score_q;
    assign bcd0  = bcd0_q;
    assign bcd1  = bcd1_q;
    assign bcd2  = bcd2_q;
    assign valid = valid_q;
    assign busy  = (state_q == SHIFT) || (state_q == DONE);

endmodule : score_to_bcd

// File: tb/tb_score_to_bcd.sv
// ---------------------------------------------------------------------------
// tb_score_to_bcd
// Directed, table-driven bench for score_to_bcd at default parameters,
// with hand-written sequences for latency, busy-time hits, reset abort,
// saturation and clear-over-hit priority.
// ---------------------------------------------------------------------------
module tb_score_to_bcd;

    localparam int SCORE_W = 10;
    localparam int SETTLE  = 2 * (SCORE_W + 2) + 6;

    logic               clk;
    logic               rst_n;
    logic               hit;
    logic               clr;
    logic [SCORE_W-1:0] score;
    logic [3:0]         bcd0, bcd1, bcd2;
    logic               busy;
    logic               valid;

    int n_vec;
    int n_err;
    int valid_cnt;
    int range_viol;

    score_to_bcd #(
        .SCORE_W   (SCORE_W),
        .MAX_SCORE (999)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hit   (hit),
        .clr   (clr),
        .score (score),
        .bcd0  (bcd0),
        .bcd1  (bcd1),
        .bcd2  (bcd2),
        .busy  (busy),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background monitors, sampled on the inactive edge.
    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt++;
        if ((bcd0 > 4'd9) || (bcd1 > 4'd9) || (bcd2 > 4'd9)) range_viol++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hits(input int n);
        if (n > 0) begin
            hit = 1'b1;
            repeat (n) tick();
            hit = 1'b0;
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic settle();
        repeat (SETTLE) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic check_digits(input string name, input int d2, input int d1, input int d0);
        check({name, "_d2"}, 32'(bcd2), 32'(d2));
        check({name, "_d1"}, 32'(bcd1), 32'(d1));
        check({name, "_d0"}, 32'(bcd0), 32'(d0));
    endtask

    typedef struct {
        bit do_clr;
        int n_hits;
        int exp_score;
        int exp_d2;
        int exp_d1;
        int exp_d0;
    } vec_t;

    vec_t vecs[10];

    initial begin : main
        int first;
        int second;
        int pre;
        logic [3:0] held;
        logic [3:0] p1_d0, p1_d1, p1_d2;
        logic [3:0] p2_d0, p2_d1, p2_d2;

        vecs[0] = '{1'b1,   0,   0, 0, 0, 0};
        vecs[1] = '{1'b0,   1,   1, 0, 0, 1};
        vecs[2] = '{1'b0,   8,   9, 0, 0, 9};
        vecs[3] = '{1'b0,   1,  10, 0, 1, 0};
        vecs[4] = '{1'b0,  89,  99, 0, 9, 9};
        vecs[5] = '{1'b0,   1, 100, 1, 0, 0};
        vecs[6] = '{1'b0, 409, 509, 5, 0, 9};
        vecs[7] = '{1'b1,  42,  42, 0, 4, 2};
        vecs[8] = '{1'b1, 123, 123, 1, 2, 3};
        vecs[9] = '{1'b0, 876, 999, 9, 9, 9};

        n_vec = 0; n_err = 0; valid_cnt = 0; range_viol = 0;
        hit = 1'b0; clr = 1'b0;

        // ---- Reset state, checked while reset is asserted -----------------
        rst_n = 1'b0;
        #3;
        check("rst_score", 32'(score), 32'd0);
        check_digits("rst", 0, 0, 0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("idle_after_rst_busy",  32'(busy),  32'd0);
        check("idle_after_rst_valid", 32'(valid_cnt), 32'd0);

        // ---- Single hit: latency, held digits, one valid pulse ------------
        pre = valid_cnt;
        do_hits(1);
        check("hit1_score", 32'(score), 32'd1);
        check("hit1_busy_e0", 32'(busy), 32'd0);
        first = 0;
        held  = 4'hF;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1)  check("hit1_busy_e1", 32'(busy), 32'd1);
            if (k == 11) held = bcd0;
            if ((valid === 1'b1) && (first == 0)) first = k;
        end
        check("hit1_latency", 32'(first), 32'd12);
        check("hit1_hold_d0", 32'(held), 32'd0);
        check("hit1_pulses", 32'(valid_cnt - pre), 32'd1);
        check_digits("hit1", 0, 0, 1);
        check("hit1_busy_end", 32'(busy), 32'd0);

        // ---- Hit while converting 7 -> conversions of 7 then 8 ------------
        do_reset();
        do_hits(6);
        settle();
        check_digits("pre7", 0, 0, 6);
        pre = valid_cnt;
        do_hits(1);
        first = 0; second = 0; held = 4'hF;
        p1_d0 = 4'hF; p1_d1 = 4'hF; p1_d2 = 4'hF;
        p2_d0 = 4'hF; p2_d1 = 4'hF; p2_d2 = 4'hF;
        for (int k = 1; k <= 40; k++) begin
            if (k == 4) hit = 1'b1;
            tick();
            if (k == 4) begin
                hit = 1'b0;
                check("busyhit_busy", 32'(busy), 32'd1);
                check("busyhit_score", 32'(score), 32'd8);
            end
            if (k == 11) held = bcd0;
            if (valid === 1'b1) begin
                if (first == 0) begin
                    first = k; p1_d0 = bcd0; p1_d1 = bcd1; p1_d2 = bcd2;
                end else if (second == 0) begin
                    second = k; p2_d0 = bcd0; p2_d1 = bcd1; p2_d2 = bcd2;
                end
            end
        end
        check("busyhit_hold_d0", 32'(held), 32'd6);
        check("busyhit_t1", 32'(first), 32'd12);
        check("busyhit_p1", 32'({p1_d2, p1_d1, p1_d0}), 32'h007);
        check("busyhit_t2", 32'(second), 32'd24);
        check("busyhit_p2", 32'({p2_d2, p2_d1, p2_d0}), 32'h008);
        check("busyhit_pulses", 32'(valid_cnt - pre), 32'd2);
        check_digits("busyhit_end", 0, 0, 8);

        // ---- Reset during the 5th SHIFT cycle of converting 37 ------------
        do_reset();
        do_hits(36);
        settle();
        check_digits("pre37", 0, 3, 6);
        do_hits(1);
        repeat (5) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_score", 32'(score), 32'd0);
        check_digits("abort", 0, 0, 0);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        pre = valid_cnt;
        settle();
        check("abort_no_pulse", 32'(valid_cnt - pre), 32'd0);
        check("abort_busy_after", 32'(busy), 32'd0);
        check_digits("abort_after", 0, 0, 0);

        // ---- 255 back-to-back hits from reset -----------------------------
        do_reset();
        do_hits(255);
        settle();
        check("b2b_score", 32'(score), 32'd255);
        check_digits("b2b", 2, 5, 5);

        // ---- Table-driven vectors (cumulative) ----------------------------
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].do_clr) do_clr();
            do_hits(vecs[i].n_hits);
            settle();
            check($sformatf("v%0d_score", i), 32'(score), 32'(vecs[i].exp_score));
            check_digits($sformatf("v%0d", i), vecs[i].exp_d2, vecs[i].exp_d1, vecs[i].exp_d0);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end

        // ---- Saturation at 999 --------------------------------------------
        pre = valid_cnt;
        do_hits(3);
        check("sat_score", 32'(score), 32'd999);
        check("sat_busy", 32'(busy), 32'd0);
        settle();
        check("sat_no_pulse", 32'(valid_cnt - pre), 32'd0);
        check_digits("sat", 9, 9, 9);

        // ---- clr and hit together at 42 -----------------------------------
        do_clr();
        do_hits(42);
        settle();
        check_digits("pre_clrhit", 0, 4, 2);
        pre = valid_cnt;
        hit = 1'b1;
        clr = 1'b1;
        tick();
        hit = 1'b0;
        clr = 1'b0;
        check("clrhit_score", 32'(score), 32'd0);
        settle();
        check("clrhit_pulses", 32'(valid_cnt - pre), 32'd1);
        check_digits("clrhit", 0, 0, 0);

        // ---- Digit range over the whole run -------------------------------
        check("digit_range", 32'(range_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_score_to_bcd

// File: doc/score_to_bcd.md
SCORE_TO_BCD -- requirements
Module: score_to_bcd

Interface
REQ-001 SHALL have parameter SCORE_W, default 10: width of the binary score register.
REQ-002 SHALL have parameter MAX_SCORE, default 999: saturation limit, at most 10^3-1.
REQ-003 SHALL have port clk, input, 1: single clock, rising-edge active for all state.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port hit, input, 1: synchronous one-cycle increment request.
REQ-006 SHALL have port clr, input, 1: synchronous score clear request.
REQ-007 SHALL have port score, output, SCORE_W: current binary score.
REQ-008 SHALL have ports bcd0, bcd1, bcd2, output, 4 each: ones, tens and hundreds digits for the downstream 7-segment decoders.
REQ-009 SHALL have port busy, output, 1: a conversion is in progress.
REQ-010 SHALL have port valid, output, 1: one-cycle pulse when new digits appear.

Function
REQ-011 SHALL increment score by 1 on a rising edge where hit=1, clr=0 and score<MAX_SCORE.
REQ-012 SHALL leave score unchanged and not request conversion when hit=1 at score=MAX_SCORE.
REQ-013 SHALL set score to 0 on a rising edge where clr=1; clr SHALL take priority over a simultaneous hit.
REQ-014 SHALL set an internal dirty flag on every score change and on every clr, including clr at score 0.
REQ-015 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-016 IDLE with dirty=1 SHALL load the shift register {12'b0, score}, clear dirty, zero the shift counter and go to SHIFT.
REQ-017 SHIFT SHALL, each cycle, add 3 to every BCD nibble >=5 and then shift the whole register left by 1.
REQ-018 SHIFT SHALL last exactly SCORE_W cycles and then go to DONE.
REQ-019 DONE SHALL copy the three nibbles to bcd2/bcd1/bcd0 in a single edge, assert valid for that cycle only, and return to IDLE.
REQ-020 SHALL hold the previous digits on bcd0..bcd2 throughout a conversion, so they never show partial values.
REQ-021 busy SHALL be 1 exactly while the state is SHIFT or DONE.
REQ-022 A hit or clr accepted while busy SHALL update score and set dirty without disturbing the running conversion.
REQ-023 After DONE, a set dirty flag SHALL start the next conversion from IDLE; only the newest score is converted and intermediate values are skipped.
REQ-024 Latency: for hit sampled at edge E0 with FSM idle, digits SHALL update at edge E0+SCORE_W+2 (E0+12 at default).
REQ-025 Every digit output SHALL be in the range 0..9 at all times.

Reset
REQ-026 rst_n=0 SHALL immediately force score=0, bcd0=bcd1=bcd2=0, busy=0, valid=0, dirty=0, state=IDLE, shift register=0 and counter=0.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion; no valid pulse SHALL follow release.
REQ-028 SHALL start no conversion after reset release until the first hit or clr.

Structure
REQ-029 The FSM state type, SCORE_W, MAX_SCORE and BCD_DIGITS=3 SHALL reside in shared package score_pkg.
REQ-030 Per-nibble add-3 correction SHALL be sub-module bcd_add3 (4-bit in, 4-bit out, combinational), instantiated once per digit.
REQ-031 bcd0..bcd2 SHALL connect directly to the existing 7-segment decoder instances with no extra logic.

Verification
REQ-032 Reset, then 1 hit -> score=1 and, 12 cycles after the hit edge, bcd2/bcd1/bcd0=0/0/1 with a single valid pulse.
REQ-033 Reset, 255 back-to-back hits -> final digits 2/5/5, at most one conversion pending at a time, no digit ever >9.
REQ-034 Preload 999 via hits, then 3 more hits -> score stays 999, no new valid pulse, digits 9/9/9.
REQ-035 hit and clr in the same cycle at score 42 -> score=0, digits 0/0/0 after conversion.
REQ-036 Drop rst_n at the 5th SHIFT cycle of converting 37 -> all outputs 0 immediately, no valid pulse after release.
REQ-037 hit while busy converting 7 -> valid pulses for 7 and then for 8, and digits end at 0/0/8.
